dmem_responder: RTL and testbench
=================================

# dmem_responder

Data-memory responder for the RISC-V core's load/store port: the memory end of the core's `wr`/`rd`/`addr`/`wr_data`/`rd_data` interface. It accepts one byte/half/word access per request, handles byte-lane steering and load sign/zero extension, and returns read data with a registered response strobe. A `ready` signal lets optional wait states stall the core.

## Interface
- `DATA_W`, 32: data width. Only 32 is supported.
- `ADDR_W`, 9: byte-address width. Storage is 2**(ADDR_W-2) words (128).
- `WAIT_CYCLES`, 2: stall cycles inserted per access. Used only when `DMEM_WAIT_STATES_EN` is defined. Legal range 1–15.

Ports:
- `clk`  in  1  clock. Rising edge is active.
- `reset`  in  1  asynchronous, active-low reset.
- `wr`  in  1  store request.
- `rd`  in  1  load request.
- `addr`  in  ADDR_W  byte address.
- `wr_data`  in  DATA_W  store data. Right-aligned: byte in [7:0], half in [15:0].
- `funct3`  in  3  access size and sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- `ready`  out  1  responder can accept a request this cycle.
- `resp_valid`  out  1  single-cycle strobe: the access completed.
- `rd_data`  out  DATA_W  extended load result. Valid with `resp_valid`; held until the next load response.
- `err`  out  1  qualified by `resp_valid`: misaligned access, illegal `funct3`, or `wr`&`rd` both high.

## Operation
- **Acceptance:** a request is accepted on a rising edge where `ready`=1 and (`wr`|`rd`)=1. Requests presented while `ready`=0 are ignored; the core holds them.
- **FSM states:** IDLE, WAIT, RESP.
  - IDLE → RESP on accept (no wait states).
  - IDLE → WAIT on accept (wait states enabled).
  - WAIT → RESP when the counter reaches WAIT_CYCLES-1.
  - RESP → RESP on a new accept (no wait states) or → WAIT (wait states enabled); otherwise RESP → IDLE.
- **`ready`:** 1 in IDLE and RESP, 0 in WAIT.
- **Store commit:** stores write the array on the accepting edge, using byte enables derived from `funct3` and `addr[1:0]`. The enabled lanes are written with the replicated low byte/half of `wr_data`.
- **Load capture:** loads read the word addressed by `addr[ADDR_W-1:2]` on the accepting edge. The selected lane is extended (sign-extend for B/H, zero-extend for BU/HU) and loaded into `rd_data` on the edge that raises `resp_valid`.
- **Alignment:** H/HU with `addr[0]`=1 is misaligned; W with `addr[1:0]`≠0 is misaligned.
- **Errors** (misaligned, illegal `funct3`, or store with `funct3`∈{100,101}):
  - no array write;
  - `rd_data` ← 0 for loads;
  - `err`=1 with `resp_valid`.
- **`wr`&`rd` both high:** the store executes, the load is dropped, and `err`=1.
- **Read after write:** a load of an address stored in the previous accepted request returns the new data.
- **Array contents:** not reset; undefined until written.

## Timing
- **Reset values:** `ready`=1, `resp_valid`=0, `rd_data`=0, `err`=0, FSM=IDLE, wait counter=0.
- **Reset mid-operation:** FSM returns to IDLE immediately and any pending response is discarded. A store already accepted remains committed.
- **Latency, no wait states:** `resp_valid` rises 1 cycle after the accepting edge. Back-to-back accepts give 1 response per cycle.
- **Latency, wait states enabled:** `resp_valid` rises WAIT_CYCLES+1 cycles after the accepting edge. Throughput is 1 access per WAIT_CYCLES+1 cycles.
- **Wait counter:** 4 bits, counts 0..WAIT_CYCLES-1, and is cleared on entry to WAIT.

## Configuration
- **`DMEM_WAIT_STATES_EN` defined:** the WAIT state, wait counter and `WAIT_CYCLES` are active. `ready` deasserts for WAIT_CYCLES cycles after each accept.
- **`DMEM_WAIT_STATES_EN` undefined:** WAIT state and counter are not built. `ready` is tied to 1 and latency is fixed at 1 cycle.

## Structure
- **Package `dmem_pkg`:**
  - `funct3` encoding constants (F3_B, F3_H, F3_W, F3_BU, F3_HU);
  - FSM state enum `dmem_state_t`;
  - `ADDR_W` default;
  - byte-enable typedef `logic [3:0]`.
- **Sub-module `dmem_lane_align`** (combinational):
  - store byte-enable and lane replication;
  - load lane select and extension;
  - misalignment/illegal detection.
- **Top:** owns the FSM, the counter and the storage array.

## Test plan
- SW 0xDEADBEEF @0x010, then LW @0x010 → `resp_valid` 1 cycle after each accept; `rd_data`=0xDEADBEEF, `err`=0.
- SB 0x80 @0x013, then LB @0x013 → `rd_data`=0xFFFFFF80. LBU @0x013 → 0x00000080. LW @0x010 → 0x80ADBEEF.
- LH @0x011 → `err`=1, `rd_data`=0. SW 0x1 @0x012 → `err`=1, word @0x010 unchanged.
- `DMEM_WAIT_STATES_EN`, WAIT_CYCLES=2: LW accepted at cycle 0 → `ready`=0 in cycles 1–2, `resp_valid` at cycle 3. A request held during WAIT is accepted at cycle 3.
- Assert `reset` low during WAIT → next cycle `ready`=1 and no `resp_valid`. A store accepted before the reset reads back as written.
- `wr`=`rd`=1, SW 0x12345678 @0x020 → `err`=1. LW @0x020 then returns 0x12345678.

Source files
------------

// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared encodings and types for the data-memory responder
package dmem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam int DMEM_ADDR_W = 9;

    typedef logic [3:0] dmem_be_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } dmem_state_t;

    function automatic logic f3_legal(input logic [2:0] f3);
        return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
               (f3 == F3_BU) || (f3 == F3_HU);
    endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// rtl/dmem_responder_if.sv - core load/store port bundle between core (master) and memory (slave)
interface dmem_responder_if
    import dmem_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = DMEM_ADDR_W
);
    logic              wr;
    logic              rd;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wr_data;
    logic [2:0]        funct3;
    logic              ready;
    logic              resp_valid;
    logic [DATA_W-1:0] rd_data;
    logic              err;

    modport master (
        output wr, rd, addr, wr_data, funct3,
        input  ready, resp_valid, rd_data, err
    );

    modport slave (
        input  wr, rd, addr, wr_data, funct3,
        output ready, resp_valid, rd_data, err
    );
endinterface

// File: rtl/dmem_lane_align.sv
// rtl/dmem_lane_align.sv - byte-lane steering, load extension and access legality checks
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic        wr,
    input  logic        rd,
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wr_data,
    input  logic [31:0] rd_word,
    output dmem_be_t    st_be,
    output logic [31:0] st_data,
    output logic [31:0] ld_data,
    output logic        acc_err
);
    logic     misalign;
    logic     fmt_err;
    dmem_be_t be_raw;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    always_comb begin
        misalign = 1'b0;
        be_raw   = '0;
        st_data  = '0;
        ld_data  = '0;
        ld_byte  = rd_word[{addr_lo, 3'b000} +: 8];
        ld_half  = rd_word[{addr_lo[1], 4'b0000} +: 16];
        case (funct3)
            F3_B, F3_BU: begin
                be_raw  = 4'b0001 << addr_lo;
                st_data = {4{wr_data[7:0]}};
                ld_data = (funct3 == F3_B) ? {{24{ld_byte[7]}}, ld_byte} : {24'b0, ld_byte};
            end
            F3_H, F3_HU: begin
                misalign = addr_lo[0];
                be_raw   = addr_lo[1] ? 4'b1100 : 4'b0011;
                st_data  = {2{wr_data[15:0]}};
                ld_data  = (funct3 == F3_H) ? {{16{ld_half[15]}}, ld_half} : {16'b0, ld_half};
            end
            F3_W: begin
                misalign = (addr_lo != 2'b00);
                be_raw   = 4'b1111;
                st_data  = wr_data;
                ld_data  = rd_word;
            end
            default: ;
        endcase
        // Unsigned sizes have no store meaning, so they are rejected for stores.
        fmt_err = misalign | ~f3_legal(funct3) | (wr & ((funct3 == F3_BU) | (funct3 == F3_HU)));
        st_be   = (wr && !fmt_err) ? be_raw : '0;
        if (fmt_err) begin
            ld_data = '0;
        end
        acc_err = fmt_err | (wr & rd);
    end
endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - data-memory responder for the core load/store port; DMEM_WAIT_STATES_EN adds wait states
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = DMEM_ADDR_W,
    parameter int WAIT_CYCLES = 2
) (
    input logic             clk,
    input logic             reset,
    dmem_responder_if.slave bus
);
    localparam int DEPTH = 2 ** (ADDR_W - 2);

    logic [DATA_W-1:0] mem [DEPTH];

    logic              accept;
    logic              ld_upd;
    dmem_be_t          st_be;
    logic [DATA_W-1:0] st_data;
    logic [DATA_W-1:0] ld_data;
    logic [DATA_W-1:0] rd_word;
    logic              acc_err;
    logic [ADDR_W-3:0] word_idx;

    dmem_state_t       state_q, state_d;
    logic              resp_valid_q, resp_valid_d;
    logic              err_q, err_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;

`ifdef DMEM_WAIT_STATES_EN
    localparam logic [3:0] WAIT_LAST = 4'(WAIT_CYCLES - 1);
    logic [3:0]        cnt_q, cnt_d;
    logic              pend_err_q, pend_err_d;
    logic              pend_ld_q, pend_ld_d;
    logic [DATA_W-1:0] pend_data_q, pend_data_d;

    assign bus.ready = (state_q != ST_WAIT);
`else
    logic [3:0] unused_wait_cycles;
    assign unused_wait_cycles = 4'(WAIT_CYCLES);
    assign bus.ready = 1'b1;
`endif

    assign word_idx = bus.addr[ADDR_W-1:2];
    assign rd_word  = mem[word_idx];
    assign accept   = bus.ready & (bus.wr | bus.rd);
    // A simultaneous store wins; the load half of the request is dropped.
    assign ld_upd   = bus.rd & ~bus.wr;

    dmem_lane_align u_align (
        .wr      (bus.wr),
        .rd      (bus.rd),
        .funct3  (bus.funct3),
        .addr_lo (bus.addr[1:0]),
        .wr_data (bus.wr_data),
        .rd_word (rd_word),
        .st_be   (st_be),
        .st_data (st_data),
        .ld_data (ld_data),
        .acc_err (acc_err)
    );

    always_ff @(posedge clk) begin
        if (accept) begin
            for (int i = 0; i < 4; i++) begin
                if (st_be[i]) begin
                    mem[word_idx][8*i +: 8] <= st_data[8*i +: 8];
                end
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        resp_valid_d = 1'b0;
        err_d        = 1'b0;
        rd_data_d    = rd_data_q;
`ifdef DMEM_WAIT_STATES_EN
        cnt_d        = cnt_q;
        pend_err_d   = pend_err_q;
        pend_ld_d    = pend_ld_q;
        pend_data_d  = pend_data_q;
`endif
        case (state_q)
            ST_IDLE, ST_RESP: begin
                if (accept) begin
`ifdef DMEM_WAIT_STATES_EN
                    state_d     = ST_WAIT;
                    cnt_d       = '0;
                    pend_err_d  = acc_err;
                    pend_ld_d   = ld_upd;
                    pend_data_d = ld_data;
`else
                    state_d      = ST_RESP;
                    resp_valid_d = 1'b1;
                    err_d        = acc_err;
                    if (ld_upd) begin
                        rd_data_d = ld_data;
                    end
`endif
                end else begin
                    state_d = ST_IDLE;
                end
            end
`ifdef DMEM_WAIT_STATES_EN
            ST_WAIT: begin
                if (cnt_q == WAIT_LAST) begin
                    state_d      = ST_RESP;
                    resp_valid_d = 1'b1;
                    err_d        = pend_err_q;
                    if (pend_ld_q) begin
                        rd_data_d = pend_data_q;
                    end
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            resp_valid_q <= 1'b0;
            err_q        <= 1'b0;
            rd_data_q    <= '0;
`ifdef DMEM_WAIT_STATES_EN
            cnt_q        <= '0;
            pend_err_q   <= 1'b0;
            pend_ld_q    <= 1'b0;
            pend_data_q  <= '0;
`endif
        end else begin
            state_q      <= state_d;
            resp_valid_q <= resp_valid_d;
            err_q        <= err_d;
            rd_data_q    <= rd_data_d;
`ifdef DMEM_WAIT_STATES_EN
            cnt_q        <= cnt_d;
            pend_err_q   <= pend_err_d;
            pend_ld_q    <= pend_ld_d;
            pend_data_q  <= pend_data_d;
`endif
        end
    end

    assign bus.resp_valid = resp_valid_q;
    assign bus.err        = err_q;
    assign bus.rd_data    = rd_data_q;
endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - scoreboard bench for dmem_responder with directed load/store vectors
module tb_dmem_responder;
    import dmem_pkg::*;

    localparam int WC = 2;
`ifdef DMEM_WAIT_STATES_EN
    localparam int EXTRA = WC;
`else
    localparam int EXTRA = 0;
`endif

    typedef struct {
        string       name;
        int          cyc;
        logic [31:0] rd;
        logic        err;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   pass_cnt = 0;
    int   total_cnt = 0;
    int   last_acc = -1;
    exp_t q[$];

    dmem_responder_if #(.DATA_W(32), .ADDR_W(9)) bus ();

    dmem_responder #(.DATA_W(32), .ADDR_W(9), .WAIT_CYCLES(WC)) dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endfunction

    always @(negedge clk) begin
        if (rst_n && bus.resp_valid) begin
            chk("resp_expected", 32'(q.size() != 0), 32'd1);
            if (q.size() != 0) begin
                exp_t e;
                e = q.pop_front();
                chk({e.name, "_latency"}, 32'(cyc), 32'(e.cyc));
                chk({e.name, "_rd_data"}, bus.rd_data, e.rd);
                chk({e.name, "_err"}, 32'(bus.err), 32'(e.err));
            end
        end
    end

    task automatic req(input string name, input logic w, input logic r, input logic [8:0] a,
                       input logic [31:0] d, input logic [2:0] f, input logic [31:0] erd,
                       input logic eerr, input bit rst_after);
        logic rdy;
        int   n;
        exp_t e;
        bus.wr = w; bus.rd = r; bus.addr = a; bus.wr_data = d; bus.funct3 = f;
        n = 0;
        do begin
            rdy = bus.ready;
            @(posedge clk);
            n++;
            if (!rdy) @(negedge clk);
        end while (!rdy && n < 50);
        #1;
        if (!rdy) begin
            chk({name, "_ready_timeout"}, 32'(rdy), 32'd1);
        end else begin
            if (last_acc >= 0) chk({name, "_accept_spacing"}, 32'(cyc - last_acc), 32'(1 + EXTRA));
            last_acc = cyc;
            if (rst_after) begin
                rst_n = 1'b0;
                last_acc = -1;
            end else begin
                e.name = name; e.cyc = cyc + EXTRA; e.rd = erd; e.err = eerr;
                q.push_back(e);
            end
        end
        @(negedge clk);
        bus.wr = 1'b0;
        bus.rd = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        bus.wr = 1'b0; bus.rd = 1'b0; bus.addr = '0; bus.wr_data = '0; bus.funct3 = F3_W;
        @(negedge clk);
        chk("reset_ready", 32'(bus.ready), 32'd1);
        chk("reset_resp_valid", 32'(bus.resp_valid), 32'd0);
        chk("reset_rd_data", bus.rd_data, 32'h0);
        chk("reset_err", 32'(bus.err), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        req("sw_10",     1, 0, 9'h010, 32'hDEADBEEF, F3_W,    32'h00000000, 0, 0);
        req("lw_10_raw", 0, 1, 9'h010, 32'h0,        F3_W,    32'hDEADBEEF, 0, 0);
        req("sb_13",     1, 0, 9'h013, 32'h00000080, F3_B,    32'hDEADBEEF, 0, 0);
        req("lb_13",     0, 1, 9'h013, 32'h0,        F3_B,    32'hFFFFFF80, 0, 0);
        req("lbu_13",    0, 1, 9'h013, 32'h0,        F3_BU,   32'h00000080, 0, 0);
        req("lw_10_b",   0, 1, 9'h010, 32'h0,        F3_W,    32'h80ADBEEF, 0, 0);
        req("lh_11_mis", 0, 1, 9'h011, 32'h0,        F3_H,    32'h00000000, 1, 0);
        req("sw_12_mis", 1, 0, 9'h012, 32'h00000001, F3_W,    32'h00000000, 1, 0);
        req("lw_10_c",   0, 1, 9'h010, 32'h0,        F3_W,    32'h80ADBEEF, 0, 0);
        req("lh_12",     0, 1, 9'h012, 32'h0,        F3_H,    32'hFFFF80AD, 0, 0);
        req("lhu_10",    0, 1, 9'h010, 32'h0,        F3_HU,   32'h0000BEEF, 0, 0);
        req("sh_16",     1, 0, 9'h016, 32'h99995A5A, F3_H,    32'h0000BEEF, 0, 0);
        req("lhu_16",    0, 1, 9'h016, 32'h0,        F3_HU,   32'h00005A5A, 0, 0);
        req("lb_16",     0, 1, 9'h016, 32'h0,        F3_B,    32'h0000005A, 0, 0);
        req("ld_f3_011", 0, 1, 9'h010, 32'h0,        3'b011,  32'h00000000, 1, 0);
        req("st_f3_bu",  1, 0, 9'h010, 32'h00000011, F3_BU,   32'h00000000, 1, 0);
        req("lw_10_d",   0, 1, 9'h010, 32'h0,        F3_W,    32'h80ADBEEF, 0, 0);
        req("wr_rd_20",  1, 1, 9'h020, 32'h12345678, F3_W,    32'h80ADBEEF, 1, 0);
        req("lw_20",     0, 1, 9'h020, 32'h0,        F3_W,    32'h12345678, 0, 0);
        req("lb_11",     0, 1, 9'h011, 32'h0,        F3_B,    32'hFFFFFFBE, 0, 0);
        req("lbu_12",    0, 1, 9'h012, 32'h0,        F3_BU,   32'h000000AD, 0, 0);
        req("sb_10",     1, 0, 9'h010, 32'hAABBCC7F, F3_B,    32'h000000AD, 0, 0);
        req("lw_10_e",   0, 1, 9'h010, 32'h0,        F3_W,    32'h80ADBE7F, 0, 0);

        req("sw_40_rst", 1, 0, 9'h040, 32'hCAFEF00D, F3_W,    32'h0,        0, 1);
        chk("midrst_ready", 32'(bus.ready), 32'd1);
        chk("midrst_resp_valid", 32'(bus.resp_valid), 32'd0);
        chk("midrst_rd_data", bus.rd_data, 32'h0);
        chk("midrst_err", 32'(bus.err), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        req("lw_40",     0, 1, 9'h040, 32'h0,        F3_W,    32'hCAFEF00D, 0, 0);

        for (int i = 0; i < 20 && q.size() != 0; i++) @(negedge clk);
        chk("drain_queue_empty", 32'(q.size()), 32'd0);
        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
